// File: rtl/eth_llc_encode_pkg.sv
// Shared types and constants for the LLC transmit framer.
package eth_llc_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, HDR, PAY, PAD} state_e;

    localparam int          ETH_HDR_LEN   = 14;
    localparam int          ETH_MIN_FRAME = 60;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_CH_NUM    = 4;
    localparam int          CNT_W         = 11;

    // Header is packed MSB-first: byte 0 lives in bits [111:104].
    function automatic logic [7:0] hdr_byte(input logic [111:0] hdr, input logic [3:0] idx);
        logic [111:0] sh;
        sh = hdr << {idx, 3'b000};
        return sh[111:104];
    endfunction
endpackage

// File: rtl/eth_llc_encode_if.sv
// Byte-wide AXI-Stream bundle; N lanes share one bundle (N=1 for the MAC side).
interface eth_llc_if
    import eth_llc_pkg::*;
#(
    parameter int N = ETH_CH_NUM
);
    logic [N-1:0][7:0] tdata;
    logic [N-1:0]      tvalid;
    logic [N-1:0]      tlast;
    logic [N-1:0]      tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/eth_llc_encode_rr_arb.sv
// Combinational 4-way round-robin arbiter; search starts one past the last grant.
module eth_llc_rr_arb
    import eth_llc_pkg::*;
(
    input  logic [ETH_CH_NUM-1:0] req_i,
    input  logic [1:0]            last_i,
    output logic [ETH_CH_NUM-1:0] gnt_o,
    output logic [1:0]            idx_o,
    output logic                  vld_o
);
    logic [1:0] c;

    always_comb begin
        gnt_o = '0;
        idx_o = last_i;
        vld_o = 1'b0;
        c     = last_i;
        for (int i = 1; i <= ETH_CH_NUM; i++) begin
            c = last_i + 2'(i);
            if (!vld_o && req_i[c]) begin
                vld_o    = 1'b1;
                idx_o    = c;
                gnt_o[c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/eth_llc_encode.sv
// LLC transmit framer: round-robin over four channels, prepends a 14-byte Ethernet header.
// ETH_LLC_ENC_PAD_EN enables zero padding of short frames to 60 bytes.
module eth_llc_encode
    import eth_llc_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h7FFF_FFFF_FFFF,
    parameter logic [15:0] PROCT_TYP = 16'hFF00
) (
    input  logic        clki,
    input  logic        rsti,
    eth_llc_if.slave    s_axis,
    eth_llc_if.master   m_axis,
    input  logic        remote_mac_en_i,
    input  logic [47:0] remote_mac_i
);
    state_e                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              ch_q, ch_d;
    logic [ETH_CH_NUM-1:0]   gnt_q, gnt_d;
    logic [47:0]             peer_q;
    logic [47:0]             dmac_q, dmac_d;
    logic [15:0]             et_q, et_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;

    logic [ETH_CH_NUM-1:0]   arb_gnt;
    logic [1:0]              arb_idx;
    logic                    arb_vld;

    logic [7:0]              out_data;
    logic                    out_valid, out_last;
    logic [ETH_CH_NUM-1:0]   s_rdy;

    eth_llc_rr_arb u_arb (
        .req_i  (s_axis.tvalid),
        .last_i (ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .vld_o  (arb_vld)
    );

    // Oversized frames keep counting at the ceiling rather than wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ch_d      = ch_q;
        gnt_d     = gnt_q;
        dmac_d    = dmac_q;
        et_d      = et_q;
        cnt_d     = cnt_q;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        s_rdy     = '0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_vld) begin
                    state_d = GRANT;
                    ptr_d   = arb_idx;
                    ch_d    = arb_idx;
                    gnt_d   = arb_gnt;
                    dmac_d  = peer_q;
                    et_d    = {PROCT_TYP[15:2], arb_idx};
                end
            end
            GRANT: state_d = HDR;
            HDR: begin
                out_data  = hdr_byte({dmac_q, LOCAL_MAC, et_q}, cnt_q[3:0]);
                out_valid = 1'b1;
                if (m_axis.tready[0]) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_W'(ETH_HDR_LEN - 1)) state_d = PAY;
                end
            end
            PAY: begin
                out_data  = s_axis.tdata[ch_q];
                out_valid = s_axis.tvalid[ch_q];
                s_rdy     = gnt_q & {ETH_CH_NUM{m_axis.tready[0]}};
`ifdef ETH_LLC_ENC_PAD_EN
                out_last  = out_valid & s_axis.tlast[ch_q]
                          & (cnt_q >= CNT_W'(ETH_MIN_FRAME - 1));
`else
                out_last  = out_valid & s_axis.tlast[ch_q];
`endif
                if (out_valid && m_axis.tready[0]) begin
                    cnt_d = cnt_inc;
                    if (s_axis.tlast[ch_q]) state_d = out_last ? IDLE : PAD;
                end
            end
`ifdef ETH_LLC_ENC_PAD_EN
            PAD: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == CNT_W'(ETH_MIN_FRAME - 1));
                if (m_axis.tready[0]) begin
                    cnt_d = cnt_inc;
                    if (out_last) state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clki) begin
        if (!rsti) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            ch_q    <= '0;
            gnt_q   <= '0;
            peer_q  <= ETH_BCAST_MAC;
            dmac_q  <= ETH_BCAST_MAC;
            et_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
            dmac_q  <= dmac_d;
            et_q    <= et_d;
            cnt_q   <= cnt_d;
            if (remote_mac_en_i) peer_q <= remote_mac_i;
        end
    end

    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign s_axis.tready = s_rdy;
endmodule

// File: tb/tb_eth_llc_encode.sv
// Directed bench for eth_llc_encode: table of single-channel frames plus arbitration,
// MAC-update and mid-frame reset sequences, checked against a byte-level frame model.
`timescale 1ns/1ps
module tb_eth_llc_encode;
    import eth_llc_pkg::*;

`ifdef ETH_LLC_ENC_PAD_EN
    localparam bit PADB = 1'b1;
`else
    localparam bit PADB = 1'b0;
`endif
    localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_B = 48'h0A0B_0C0D_0E0F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_llc_if #(.N(ETH_CH_NUM)) s_if();
    eth_llc_if #(.N(1))          m_if();

    logic        mac_en = 1'b0;
    logic [47:0] mac    = '0;
    logic [7:0]  d [4];
    logic        v [4];
    logic        l [4];
    logic        m_rdy   = 1'b1;
    bit          rnd_rdy = 1'b0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_if.tdata[i]  = d[i];
            s_if.tvalid[i] = v[i];
            s_if.tlast[i]  = l[i];
        end
    end
    assign m_if.tready = m_rdy;

    eth_llc_encode dut (
        .clki            (clk),
        .rsti            (rst_n),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .remote_mac_en_i (mac_en),
        .remote_mac_i    (mac)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] got_b[$];
    bit         got_l[$];
    logic [7:0] exp_b[$];
    bit         exp_l[$];
    int         nfr = 0;
    int         unstable = 0;

    // Output monitor and AXI hold check, sampled mid-cycle.
    logic [7:0] pd;
    logic       pv = 1'b0, pl = 1'b0, prdy = 1'b1, prst = 1'b0;
    always @(negedge clk) begin
        if (rst_n && m_if.tvalid[0] && m_if.tready[0]) begin
            got_b.push_back(m_if.tdata[0]);
            got_l.push_back(m_if.tlast[0]);
            if (m_if.tlast[0]) nfr++;
        end
        if (prst && rst_n && pv && !prdy &&
            (m_if.tvalid[0] !== 1'b1 || m_if.tdata[0] !== pd || m_if.tlast[0] !== pl))
            unstable++;
        pd   = m_if.tdata[0];
        pv   = m_if.tvalid[0];
        pl   = m_if.tlast[0];
        prdy = m_if.tready[0];
        prst = rst_n;
    end

    always begin
        @(posedge clk);
        #1;
        m_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    function automatic logic [7:0] gb(input int i);
        if (i >= 0 && i < got_b.size()) return got_b[i];
        return 8'hxx;
    endfunction

    function automatic logic [47:0] gmac(input int o);
        return {gb(o), gb(o + 1), gb(o + 2), gb(o + 3), gb(o + 4), gb(o + 5)};
    endfunction

    function automatic int lastidx();
        for (int i = 0; i < got_l.size(); i++) if (got_l[i]) return i;
        return -1;
    endfunction

    function automatic void add_exp(input logic [47:0] dm, input int ch, input int len,
                                    input logic [7:0] base);
        int n;
        for (int i = 0; i < 6; i++) begin
            exp_b.push_back(8'(dm >> (40 - 8 * i)));
            exp_l.push_back(1'b0);
        end
        exp_b.push_back(8'h7F);
        exp_l.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_b.push_back(8'hFF);
            exp_l.push_back(1'b0);
        end
        exp_b.push_back(8'hFF);
        exp_l.push_back(1'b0);
        exp_b.push_back(8'(ch));
        exp_l.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            exp_b.push_back(8'(base + 8'(i)));
            exp_l.push_back(1'b0);
        end
        n = 14 + len;
        if (PADB) begin
            while (n < 60) begin
                exp_b.push_back(8'h00);
                exp_l.push_back(1'b0);
                n++;
            end
        end
        exp_l[exp_l.size() - 1] = 1'b1;
    endfunction

    task automatic chk_stream(input string name);
        int bad;
        bad = -1;
        if (got_b.size() == exp_b.size())
            for (int i = 0; i < exp_b.size(); i++)
                if (bad < 0 && (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i])) bad = i;
        checks++;
        if (got_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL %s: got %0d bytes expected %0d", name, got_b.size(), exp_b.size());
        end else if (bad >= 0) begin
            errors++;
            $display("FAIL %s: byte %0d got %0h/last %0d expected %0h/last %0d", name, bad,
                     got_b[bad], got_l[bad], exp_b[bad], exp_l[bad]);
        end
    endtask

    task automatic clr();
        got_b.delete();
        got_l.delete();
        exp_b.delete();
        exp_l.delete();
        nfr = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the last byte is accepted.
    task automatic send_frame(input int ch, input int len, input logic [7:0] base, input bit rnd);
        logic [1:0] c;
        bit acc;
        int t;
        c = 2'(ch);
        for (int i = 0; i < len; i++) begin
            if (rnd && $urandom_range(0, 1) == 1) begin
                v[c] = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            d[c] = 8'(base + 8'(i));
            v[c] = 1'b1;
            l[c] = (i == len - 1);
            acc = 1'b0;
            t = 0;
            while (!acc && t < 5000) begin
                @(negedge clk);
                acc = s_if.tready[c];
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send ch%0d timeout: byte %0d not accepted in %0d cycles", ch, i, t);
            end
        end
        v[c] = 1'b0;
        l[c] = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string name);
        int t;
        t = 0;
        while (nfr < n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (nfr < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d frames expected %0d", name, nfr, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    typedef struct {
        int         ch;
        int         len;
        logic [7:0] base;
        bit         rnd;
        int         tot;
        int         last;
    } vec_t;
    vec_t vt[5];

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached before end of test");
        finish_sim();
    end

    initial begin
        logic [111:0] gh;
        int t;

        vt[0] = '{2, 46, 8'h10, 1'b0, 60, 59};
        vt[1] = '{0, 10, 8'hA0, 1'b0, PADB ? 60 : 24, PADB ? 59 : 23};
        vt[2] = '{1, 46, 8'h30, 1'b1, 60, 59};
        vt[3] = '{3, 70, 8'h55, 1'b1, 84, 83};
        vt[4] = '{0, 1, 8'hE0, 1'b1, PADB ? 60 : 15, PADB ? 59 : 14};

        for (int i = 0; i < 4; i++) begin
            d[i] = '0;
            v[i] = 1'b0;
            l[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {m_if.tvalid, m_if.tlast, m_if.tdata, s_if.tready}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All channels requesting: round-robin order from the reset pointer.
        clr();
        add_exp(ETH_BCAST_MAC, 0, 50, 8'h00);
        add_exp(ETH_BCAST_MAC, 1, 50, 8'h40);
        add_exp(ETH_BCAST_MAC, 2, 50, 8'h80);
        add_exp(ETH_BCAST_MAC, 3, 50, 8'hC0);
        add_exp(ETH_BCAST_MAC, 0, 50, 8'h20);
        fork
            begin
                send_frame(0, 50, 8'h00, 1'b0);
                send_frame(0, 50, 8'h20, 1'b0);
            end
            send_frame(1, 50, 8'h40, 1'b0);
            send_frame(2, 50, 8'h80, 1'b0);
            send_frame(3, 50, 8'hC0, 1'b0);
        join
        wait_frames(5, "rr");
        chk_stream("rr_stream");
        chk("rr_ethertype_order", {gb(13), gb(77), gb(141), gb(205), gb(269)}, 40'h00_01_02_03_00);
        chk("bcast_dmac", gmac(0), ETH_BCAST_MAC);

        @(posedge clk);
        #1;
        mac = MAC_A;
        mac_en = 1'b1;
        @(posedge clk);
        #1;
        mac_en = 1'b0;

        for (int k = 0; k < 5; k++) begin
            clr();
            add_exp(MAC_A, vt[k].ch, vt[k].len, vt[k].base);
            rnd_rdy = vt[k].rnd;
            send_frame(vt[k].ch, vt[k].len, vt[k].base, vt[k].rnd);
            wait_frames(1, $sformatf("vec%0d", k));
            rnd_rdy = 1'b0;
            chk($sformatf("vec%0d_bytes", k), got_b.size(), vt[k].tot);
            chk($sformatf("vec%0d_tlast_idx", k), lastidx(), vt[k].last);
            chk_stream($sformatf("vec%0d_stream", k));
            if (k == 0) begin
                gh = '0;
                for (int i = 0; i < 14; i++) gh = {gh[103:0], gb(i)};
                chk("vec0_header", gh, 112'h0011_2233_4455_7FFF_FFFF_FFFF_FF02);
            end
        end

        // Peer MAC changes mid-payload: only the following frame sees it.
        clr();
        add_exp(MAC_A, 1, 30, 8'h70);
        add_exp(MAC_B, 1, 30, 8'h90);
        fork
            send_frame(1, 30, 8'h70, 1'b0);
            begin
                repeat (25) @(posedge clk);
                #1;
                mac = MAC_B;
                mac_en = 1'b1;
                @(posedge clk);
                #1;
                mac_en = 1'b0;
            end
        join
        wait_frames(1, "mac_upd_f0");
        send_frame(1, 30, 8'h90, 1'b0);
        wait_frames(2, "mac_upd_f1");
        chk_stream("mac_upd_stream");
        chk("mac_upd_old", gmac(0), MAC_A);
        chk("mac_upd_new", gmac(PADB ? 60 : 44), MAC_B);

        // Reset during the header of a ch1 frame, then a clean regrant.
        clr();
        add_exp(ETH_BCAST_MAC, 1, 20, 8'hB0);
        fork
            send_frame(1, 20, 8'hB0, 1'b0);
            begin
                t = 0;
                while (m_if.tvalid[0] !== 1'b1 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("mid_reset_outputs", {m_if.tvalid, m_if.tlast, m_if.tdata, s_if.tready}, '0);
                got_b.delete();
                got_l.delete();
                nfr = 0;
            end
        join
        wait_frames(1, "rst_regrant");
        chk_stream("rst_regrant_stream");
        chk("rst_dmac", gmac(0), ETH_BCAST_MAC);

        chk("axi_hold_violations", unstable, 0);
        finish_sim();
    end
endmodule
